// File: rtl/data_buffer.sv
// data_buffer -- staging buffer between the AHB subordinate and the inference
// controller.
//
// Three FIFOs, 64-bit words:
//   weight FIFO (8 deep)           : filled by AHB writes (wr_sel = 0),
//                                    drained by get_weights
//   input FIFO  (INPUT_DEPTH deep) : filled by AHB writes (wr_sel = 1),
//                                    drained by get_inputs
//   output FIFO (INPUT_DEPTH deep) : filled by array_out_valid in RUN,
//                                    drained by rd_en
//
// Ports
//   clk, n_rst            clock, async active-low reset
//   wr_en/wr_sel/wr_data  AHB write into weight or input FIFO
//   rd_en/rd_data         AHB pop of the output FIFO (rd_data registered)
//   clr_err               clear sticky occupancy_err (a new error wins)
//   get_weights/get_inputs/get_out  controller requests
//   data/data_ready       fetched word, valid for one cycle after the request
//   num_inputs            input count (live in IDLE, frozen after first get_inputs)
//   out_done              pulse when all results are captured and get_out is high
//   output_valid          results available to the AHB
//   occupancy_err         sticky misuse flag
//   array_out/array_out_valid  systolic-array result stream
//
// Build option: DATA_BUFFER_WEIGHT_RETAIN_EN -- weight fetches do not consume
// entries; the read pointer wraps modulo the weight count so the same weights
// can be reloaded without rewriting them.

module data_buffer_fifo #(
  parameter int DEPTH  = 8,
  parameter bit RETAIN = 1'b0,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,   // already qualified (not full, or freed by pop)
  input  logic          pop,    // already qualified (not empty)
  input  logic [63:0]   wdata,
  output logic [63:0]   head,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  // Storage is not reset; an empty count makes stale contents unreachable.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        // Retained entries always start at index 0, so wrapping at count
        // replays exactly the stored set.
        if (RETAIN && (CW'(rd_ptr) + CW'(1) == count)) rd_ptr <= '0;
        else                                           rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !(pop && !RETAIN))      count <= count + CW'(1);
      else if (!push && pop && !RETAIN)   count <= count - CW'(1);
    end
  end
endmodule

module data_buffer #(
  parameter int INPUT_DEPTH = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [63:0] wr_data,
  input  logic        rd_en,
  output logic [63:0] rd_data,
  input  logic        clr_err,
  input  logic        get_weights,
  input  logic        get_inputs,
  input  logic        get_out,
  output logic [63:0] data,
  output logic        data_ready,
  output logic [6:0]  num_inputs,
  output logic        out_done,
  output logic        output_valid,
  output logic        occupancy_err,
  input  logic [63:0] array_out,
  input  logic        array_out_valid
);
`ifdef DATA_BUFFER_WEIGHT_RETAIN_EN
  localparam bit W_RETAIN = 1'b1;
`else
  localparam bit W_RETAIN = 1'b0;
`endif
  localparam int W_DEPTH = 8;
  localparam int WCW     = $clog2(W_DEPTH + 1);
  localparam int ICW     = $clog2(INPUT_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state;

  logic [6:0]     num_lat, cap_cnt;
  logic [WCW-1:0] w_count;
  logic [ICW-1:0] i_count, o_count;
  logic [63:0]    w_head, i_head, o_head;

  // Fetch arbitration: one fetch in flight; weights win a same-cycle tie.
  logic fetch_req, fetch_acc, fetch_w, fetch_i;
  assign fetch_req = get_weights | get_inputs;
  assign fetch_acc = fetch_req & ~data_ready;
  assign fetch_w   = fetch_acc & get_weights;
  assign fetch_i   = fetch_acc & ~get_weights;

  // Qualified FIFO operations. A full FIFO still takes a push when a pop
  // frees a slot in the same cycle (not for retained weights).
  logic w_pop, w_push, i_pop, i_push, o_pop, o_push, o_cap;
  assign w_pop  = fetch_w & (w_count != '0);
  assign w_push = wr_en & ~wr_sel & ((w_count != WCW'(W_DEPTH)) | (w_pop & !W_RETAIN));
  assign i_pop  = fetch_i & (i_count != '0);
  assign i_push = wr_en & wr_sel & ((i_count != ICW'(INPUT_DEPTH)) | i_pop);
  assign o_pop  = rd_en & (o_count != '0);
  assign o_cap  = array_out_valid & (state == S_RUN);
  assign o_push = o_cap & ((o_count != ICW'(INPUT_DEPTH)) | o_pop);

  data_buffer_fifo #(.DEPTH(W_DEPTH), .RETAIN(W_RETAIN), .CW(WCW)) u_wfifo (
    .clk(clk), .n_rst(n_rst), .push(w_push), .pop(w_pop), .wdata(wr_data),
    .head(w_head), .count(w_count));

  data_buffer_fifo #(.DEPTH(INPUT_DEPTH), .RETAIN(1'b0), .CW(ICW)) u_ififo (
    .clk(clk), .n_rst(n_rst), .push(i_push), .pop(i_pop), .wdata(wr_data),
    .head(i_head), .count(i_count));

  data_buffer_fifo #(.DEPTH(INPUT_DEPTH), .RETAIN(1'b0), .CW(ICW)) u_ofifo (
    .clk(clk), .n_rst(n_rst), .push(o_push), .pop(o_pop), .wdata(array_out),
    .head(o_head), .count(o_count));

  logic err_set;
  assign err_set = (wr_en & ~wr_sel & ~w_push) | (wr_en & wr_sel & ~i_push)
                 | (fetch_w & ~w_pop) | (fetch_i & ~i_pop)
                 | (get_weights & get_inputs) | (fetch_req & data_ready)
                 | (o_cap & ~o_push) | (rd_en & ~o_pop);

  assign num_inputs = (state == S_IDLE) ? 7'(i_count) : num_lat;
  assign out_done   = (state == S_RUN) && get_out && (cap_cnt == num_lat);

  // Fetch and AHB read datapath
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data          <= '0;
      data_ready    <= 1'b0;
      rd_data       <= '0;
      occupancy_err <= 1'b0;
    end else begin
      data_ready <= fetch_acc;
      if (fetch_w)      data <= w_pop ? w_head : '0;
      else if (fetch_i) data <= i_pop ? i_head : '0;
      else              data <= '0;
      if (rd_en) rd_data <= o_pop ? o_head : '0;
      occupancy_err <= err_set | (occupancy_err & ~clr_err);
    end
  end

  // Inference state machine
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      num_lat      <= '0;
      cap_cnt      <= '0;
      output_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (fetch_i) begin
            num_lat <= 7'(i_count);
            cap_cnt <= '0;
            state   <= S_RUN;
          end
        S_RUN: begin
          if (o_push) cap_cnt <= cap_cnt + 7'd1;
          if (out_done) begin
            output_valid <= 1'b1;
            state        <= S_DRAIN;
          end
        end
        S_DRAIN:
          if (o_count == '0 || (o_count == ICW'(1) && o_pop)) begin
            output_valid <= 1'b0;
            state        <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer: randomized data against a queue-based
// behavioural model of the three FIFOs and the inference phases.
module tb_data_buffer;
  localparam int DEPTH = 64;
`ifdef DATA_BUFFER_WEIGHT_RETAIN_EN
  localparam bit RETAIN = 1'b1;
`else
  localparam bit RETAIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        wr_en = 0, wr_sel = 0, rd_en = 0, clr_err = 0;
  logic        get_weights = 0, get_inputs = 0, get_out = 0, array_out_valid = 0;
  logic [63:0] wr_data = '0, array_out = '0;
  logic [63:0] rd_data, data;
  logic        data_ready, out_done, output_valid, occupancy_err;
  logic [6:0]  num_inputs;

  always #5 clk = ~clk;

  data_buffer #(.INPUT_DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .clr_err(clr_err),
    .get_weights(get_weights), .get_inputs(get_inputs), .get_out(get_out),
    .data(data), .data_ready(data_ready), .num_inputs(num_inputs),
    .out_done(out_done), .output_valid(output_valid), .occupancy_err(occupancy_err),
    .array_out(array_out), .array_out_valid(array_out_valid));

  int n_chk = 0, n_pass = 0;

  // Reference model: contents as queues, phase 0=IDLE 1=RUN 2=DRAIN
  logic [63:0] wq[$], iq[$], oq[$];
  int widx, phase, m_num, m_cap;
  bit m_err, m_ov;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic m_write(input bit sel, input logic [63:0] v);
    if (!sel) begin
      if (wq.size() < 8) wq.push_back(v); else m_err = 1;
    end else begin
      if (iq.size() < DEPTH) iq.push_back(v); else m_err = 1;
    end
  endtask

  task automatic m_fetch_w(output logic [63:0] e);
    if (wq.size() == 0) begin e = '0; m_err = 1; end
    else if (RETAIN) begin e = wq[widx]; widx = (widx + 1) % wq.size(); end
    else e = wq.pop_front();
  endtask

  task automatic m_fetch_i(output logic [63:0] e);
    if (phase == 0) begin m_num = iq.size(); m_cap = 0; phase = 1; end
    if (iq.size() == 0) begin e = '0; m_err = 1; end
    else e = iq.pop_front();
  endtask

  task automatic chk_num(input string tag);
    chk(tag, 64'(num_inputs), (phase == 0) ? 64'(iq.size()) : 64'(m_num));
  endtask

  task automatic do_reset();
    n_rst = 0; #2;
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_drdy", 64'(data_ready), 64'd0);
    chk("rst_num", 64'(num_inputs), 64'd0);
    chk("rst_done", 64'(out_done), 64'd0);
    chk("rst_ovalid", 64'(output_valid), 64'd0);
    chk("rst_err", 64'(occupancy_err), 64'd0);
    wq.delete(); iq.delete(); oq.delete();
    widx = 0; phase = 0; m_num = 0; m_cap = 0; m_err = 0; m_ov = 0;
    @(negedge clk); n_rst = 1;
    tick();
  endtask

  task automatic wr(input bit sel, input logic [63:0] v);
    wr_en = 1; wr_sel = sel; wr_data = v;
    m_write(sel, v);
    tick();
    wr_en = 0; wr_sel = 0;
  endtask

  // One fetch spanning 3 cycles: request, data_ready, data back to 0.
  task automatic fetch(input bit w);
    logic [63:0] e;
    get_weights = w; get_inputs = !w;
    if (w) m_fetch_w(e); else m_fetch_i(e);
    tick();
    get_weights = 0; get_inputs = 0;
    chk(w ? "w_drdy" : "i_drdy", 64'(data_ready), 64'd1);
    chk(w ? "w_data" : "i_data", data, e);
    chk("fetch_err", 64'(occupancy_err), 64'(m_err));
    tick();
    chk("drdy_clr", 64'(data_ready), 64'd0);
    chk("data_clr", data, 64'd0);
    tick();
  endtask

  task automatic clr();
    clr_err = 1; m_err = 0;
    tick();
    clr_err = 0;
    chk("clr_err", 64'(occupancy_err), 64'(m_err));
  endtask

  task automatic capture(input logic [63:0] v);
    array_out = v; array_out_valid = 1;
    if (phase == 1) begin
      if (oq.size() < DEPTH) begin oq.push_back(v); m_cap++; end
      else m_err = 1;
    end
    tick();
    array_out_valid = 0;
  endtask

  // get_out held two cycles: out_done may only show in the first.
  task automatic req_out();
    bit e;
    get_out = 1; #1;
    e = (phase == 1) && (m_cap == m_num);
    chk("out_done", 64'(out_done), 64'(e));
    tick();
    if (e) begin phase = 2; m_ov = 1; end
    chk("out_done_1cyc", 64'(out_done), 64'd0);
    chk("out_valid_set", 64'(output_valid), 64'(m_ov));
    get_out = 0;
  endtask

  task automatic rd_pop();
    logic [63:0] e;
    rd_en = 1;
    if (oq.size() == 0) begin e = '0; m_err = 1; end
    else e = oq.pop_front();
    if (phase == 2 && oq.size() == 0) begin m_ov = 0; phase = 0; end
    tick();
    rd_en = 0;
    chk("rd_data", rd_data, e);
    chk("rd_ovalid", 64'(output_valid), 64'(m_ov));
    chk("rd_err", 64'(occupancy_err), 64'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] e, v;
    int k;
    #1;
    do_reset();

    // Weights 1..8, fetched in order
    for (int i = 1; i <= 8; i++) wr(1'b0, 64'(i));
    chk("w_fill_err", 64'(occupancy_err), 64'd0);
    for (int i = 0; i < 8; i++) fetch(1'b1);

    // Ninth weight dropped; retained build replays the set twice
    do_reset();
    for (int i = 1; i <= 9; i++) wr(1'b0, 64'(i));
    chk("w_ovf_err", 64'(occupancy_err), 64'(m_err));
    clr();
    for (int i = 0; i < (RETAIN ? 16 : 9); i++) fetch(1'b1);

    // Push and pop on a full weight FIFO in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) wr(1'b0, rnd64());
    v = rnd64();
    get_weights = 1; wr_en = 1; wr_sel = 0; wr_data = v;
    m_fetch_w(e); m_write(1'b0, v);
    tick();
    get_weights = 0; wr_en = 0;
    chk("full_pp_data", data, e);
    chk("full_pp_err", 64'(occupancy_err), 64'(m_err));
    tick(); tick();
    for (int i = 0; i < 8; i++) fetch(1'b1);

    // Empty input fetch, then error clear
    do_reset();
    fetch(1'b0);
    clr();

    // Same-cycle get_weights + get_inputs (in RUN): weights served
    wr(1'b0, rnd64());
    wr(1'b1, rnd64());
    chk_num("num_run_frozen");
    get_weights = 1; get_inputs = 1;
    m_fetch_w(e); m_err = 1;
    tick();
    get_weights = 0; get_inputs = 0;
    chk("both_data", data, e);
    chk("both_err", 64'(occupancy_err), 64'(m_err));
    tick(); tick();
    clr();
    fetch(1'b0);

    // Request while a fetch is pending is dropped
    clr();
    wr(1'b0, rnd64());
    wr(1'b0, rnd64());
    get_weights = 1;
    m_fetch_w(e);
    tick();
    chk("pend_data", data, e);
    m_err = 1;
    tick();
    get_weights = 0;
    chk("pend_drdy", 64'(data_ready), 64'd0);
    chk("pend_err", 64'(occupancy_err), 64'(m_err));
    tick();
    fetch(1'b1);

    // Reset while in RUN, then an empty input fetch
    do_reset();
    fetch(1'b0);

    // Inference runs: first with 3 inputs, then random sizes
    for (int r = 0; r < 4; r++) begin
      do_reset();
      k = (r == 0) ? 3 : int'($urandom_range(1, 8));
      for (int i = 0; i < k; i++) wr(1'b1, rnd64());
      chk_num("num_idle");
      fetch(1'b0);
      chk_num("num_latched");
      wr(1'b1, rnd64());
      chk_num("num_after_wr");
      for (int i = 0; i < k - 1; i++) capture(rnd64());
      req_out();
      capture(rnd64());
      req_out();
      capture(rnd64());
      for (int i = 0; i < k; i++) rd_pop();
      rd_pop();
      chk_num("num_back_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_buffer.md
# data_buffer

On-chip staging buffer between the AHB subordinate and the inference controller. It holds three FIFOs: an 8-word weight FIFO and an input FIFO, both filled by AHB writes, and an output FIFO that captures systolic-array results and is drained by AHB reads. It serves the controller's get_weights/get_inputs/get_out handshakes and reports data_ready, num_inputs, out_done, output_valid and a sticky occupancy_err.

## Interface
Parameters:
- INPUT_DEPTH, 64: entries in the input FIFO and in the output FIFO, each 64 bits; power of two, at most 64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  AHB write strobe.
- wr_sel  input  1  write target: 0 = weight FIFO, 1 = input FIFO.
- wr_data  input  64  AHB write word.
- rd_en  input  1  AHB pop strobe for the output FIFO.
- rd_data  output  64  popped output word, registered.
- clr_err  input  1  synchronous clear of occupancy_err.
- get_weights / get_inputs / get_out  input  1 each  controller requests.
- data  output  64  word returned to the controller.
- data_ready  output  1  one-cycle pulse; data is valid in the same cycle.
- num_inputs  output  7  input word count used for the inference.
- out_done  output  1  one-cycle pulse when all results are captured.
- output_valid  output  1  results are available to the AHB.
- occupancy_err  output  1  sticky FIFO misuse flag.
- array_out  input  64  systolic-array result word.
- array_out_valid  input  1  array_out is valid this cycle.

## Operation
- FIFOs use separate read and write pointers plus a count. A write to a full FIFO is dropped and sets occupancy_err. A push and a pop in the same cycle on a full FIFO are both accepted.
- Fetch path: get_weights or get_inputs pops the head of the selected FIFO into a data register. data_ready pulses in the following cycle. If the selected FIFO is empty, data = 0, data_ready still pulses so the controller never hangs, and occupancy_err is set.
- If get_weights and get_inputs arrive in the same cycle, get_weights is served, get_inputs is dropped, and occupancy_err is set.
- A request arriving while a fetch is pending is dropped and sets occupancy_err.
- Inference state machine:
  - IDLE: num_inputs follows the input FIFO count. The first get_inputs latches the count into num_inputs, clears the output count, and moves to RUN.
  - RUN: num_inputs is frozen. Every array_out_valid pushes array_out into the output FIFO and increments the capture count. When get_out = 1 and the capture count equals num_inputs, out_done pulses for one cycle, output_valid sets, and the state moves to DRAIN.
  - DRAIN: array_out_valid is ignored. output_valid clears in the cycle the output FIFO becomes empty. Then the state returns to IDLE.
- In RUN, a capture into a full output FIFO is dropped and sets occupancy_err.
- Input-FIFO writes in RUN are accepted but do not change num_inputs.
- rd_en pops the output FIFO into rd_data, valid the next cycle. rd_en on an empty FIFO gives rd_data = 0 and sets occupancy_err.
- occupancy_err: clr_err clears it. If clr_err and a new error occur in the same cycle, the error wins.

## Timing
- Reset values: rd_data = 0, data = 0, data_ready = 0, num_inputs = 0, out_done = 0, output_valid = 0, occupancy_err = 0. All FIFOs are empty and the state machine is in IDLE.
- Fetch latency: request in cycle N, data_ready and data in cycle N+1. data returns to 0 in N+2.
- AHB writes: a write in cycle N is visible to a fetch in cycle N+1. num_inputs updates in N+1.
- out_done: asserted combinationally off registered state in the first get_out = 1 cycle that meets the count condition; never held for two cycles.
- Reset mid-operation: all FIFO contents are discarded and outputs return to their reset values.

## Configuration
- DATA_BUFFER_WEIGHT_RETAIN_EN:
  - Defined: weight fetches do not decrement the weight count. The read pointer wraps modulo the count, so the same weights can be reloaded without rewriting them. The empty-FIFO error still applies when the count is 0.
  - Undefined: weight fetches pop normally.

## Test plan
- Write 8 weight words 0x01..0x08 (wr_sel = 0), then 8 get_weights pulses spaced 3 cycles apart -> each data_ready arrives 1 cycle after its request, data = 0x01..0x08 in order, occupancy_err = 0.
- Write 3 input words, get_inputs -> num_inputs = 3 and frozen. A 4th write leaves num_inputs at 3.
- In RUN with num_inputs = 3, drive 3 array_out_valid words, then get_out -> out_done pulses in the first get_out cycle, output_valid = 1. Three rd_en pulses return the words in order; output_valid drops after the third pop.
- get_inputs with an empty input FIFO -> data_ready pulses with data = 0 and occupancy_err = 1. clr_err clears it the next cycle.
- Write 9 weight words -> the 9th is dropped and occupancy_err = 1. With DATA_BUFFER_WEIGHT_RETAIN_EN defined, 16 fetches return 0x01..0x08 twice.
- Assert n_rst during RUN -> all outputs return to reset values; a following get_inputs reports an empty-FIFO error.
